dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the dual-port data memory (16-bit scalar port A, 256-bit vector port B, selected by src_sel) between two requesters: the SIMD processor and a bulk loader that fills or drains image buffers.
- Sits between the requesters and dmem, issuing at most one access per cycle.
- Tracks the one-cycle dmem read latency and returns read data to the requester that issued the read.
- Processor normally has priority. A starvation counter and a loader burst lock bound the wait time for each side.

Parameters:
- STARVE_LIMIT, 8, consecutive processor-won cycles with loader waiting before the loader is forced through.
- MAX_BURST, 16, maximum consecutive loader grants under lock while the processor is requesting.
- AW, 32, address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p_req  in  1  processor access request
- p_we  in  1  processor write enable
- p_vec  in  1  processor port select: 0 = scalar port A, 1 = vector port B
- p_addr  in  AW  processor address
- p_wdata_a  in  16  processor scalar write data
- p_wdata_b  in  256  processor vector write data
- p_gnt  out  1  processor access accepted this cycle
- p_rvalid  out  1  processor read data valid
- p_rdata_a  out  16  processor scalar read data
- p_rdata_b  out  256  processor vector read data
- l_req, l_we, l_vec, l_addr, l_wdata_a, l_wdata_b  in  1/1/1/AW/16/256  loader request set, same meaning as the p_ set
- l_lock  in  1  loader requests to keep ownership across consecutive beats
- l_gnt, l_rvalid, l_rdata_a, l_rdata_b  out  1/1/16/256  loader grant and response set, same meaning as the p_ set
- mem_we  out  1  to dmem write enable
- mem_src_sel  out  1  to dmem port select
- mem_addr  out  AW  to dmem address
- mem_wdata_a  out  16  to dmem scalar write data
- mem_wdata_b  out  256  to dmem vector write data
- mem_q_a  in  16  from dmem scalar read data
- mem_q_b  in  256  from dmem vector read data

Behaviour:
- Grant is combinational in the request cycle. The winner's we/vec/addr/wdata are muxed onto the mem_* ports in that same cycle.
- With no grant: mem_we = 0, mem_src_sel = 0, mem_addr = 0, mem_wdata_* = 0.
- Access completes when req and gnt are both high. A requester holds its request fields stable until granted.
- Only one grant per cycle: p_gnt and l_gnt are never high together.
- State machine, registered, async reset to P_PRIO:
  - P_PRIO:
    - p_req → grant processor. If l_req is also high, starve_cnt++.
    - Only l_req → grant loader; starve_cnt = 0. If l_lock is also high, go to L_BURST with burst_cnt = 1.
    - Transition: starve_cnt reaches STARVE_LIMIT → L_FORCE.
  - L_FORCE:
    - l_req → grant loader (even if p_req); starve_cnt = 0.
    - Next state is L_BURST with burst_cnt = 1 if l_lock, else P_PRIO.
    - If l_req dropped, return to P_PRIO with no grant change.
  - L_BURST:
    - l_req && l_lock → grant loader, burst_cnt++.
    - Exit to P_PRIO when l_req or l_lock is low, or when burst_cnt == MAX_BURST && p_req. In the exit cycle, fall through to P_PRIO rules in that same cycle.
    - With p_req low, the burst is unbounded; burst_cnt saturates at MAX_BURST.
- Read return:
  - A granted access with we = 0 sets a registered rd_owner/rd_valid tag.
  - In cycle t+1, the owner's rvalid pulses for one cycle and its rdata_a/rdata_b carry mem_q_a/mem_q_b.
  - The non-owner's rdata is 0.
  - Back-to-back reads from alternating owners return in issue order, one per cycle.
  - Writes produce no rvalid.
- Counters:
  - starve_cnt is 4 bits wide, saturating.
  - starve_cnt clears whenever the loader is granted or l_req is low.
- Reset (async, mid-operation included):
  - State → P_PRIO; starve_cnt, burst_cnt, rd_valid → 0.
  - p_gnt, l_gnt, p_rvalid, l_rvalid, mem_we are all forced 0 while reset is high.
  - A read issued in the cycle before reset asserts returns no rvalid.

Test Plan:
- Processor-only reads: p_req, p_vec = 0, p_addr = 0x10 for 3 cycles → p_gnt = 1 each cycle; p_rvalid pulses at t+1, t+2, t+3 with p_rdata_a = mem_q_a; l_rvalid stays 0.
- Contention/starvation: p_req and l_req held high, STARVE_LIMIT = 8 → processor granted 8 cycles, loader granted in the 9th, processor granted in the 10th.
- Loader burst: l_req and l_lock high, p_req rising at beat 3 → loader keeps l_gnt through beat 16 (MAX_BURST); p_gnt in the next cycle.
- Vector write pass-through: l_we = 1, l_vec = 1, l_wdata_b = {16{16'hA5A5}} → in the same cycle mem_we = 1, mem_src_sel = 1, mem_wdata_b matches; no l_rvalid afterwards.
- Alternating reads: processor read at t, loader read at t+1 → p_rvalid at t+1, l_rvalid at t+2, each with its own data.
- Reset mid-burst: assert reset during L_BURST beat 5 → all grants and rvalids drop 0 asynchronously; after release, p_req alone is granted immediately (state P_PRIO).

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the dual-port data memory (16-bit scalar port A, 256-bit vector
//   port B) between the SIMD processor (p_*) and the image-buffer bulk
//   loader (l_*). At most one access is issued per cycle; the grant is
//   combinational in the request cycle and the winner's request fields are
//   muxed straight onto mem_*. Read data returns one cycle later to the
//   requester that issued the read.
//
//   Priority: processor first. A 4-bit saturating starvation counter forces
//   the loader through after STARVE_LIMIT consecutive processor wins while
//   the loader waits; a loader holding l_lock keeps ownership for up to
//   MAX_BURST beats while the processor is requesting (unbounded otherwise).
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   p_req/we/vec/addr/wdata_*  processor request set
//   p_gnt, p_rvalid, p_rdata_* processor grant and read response
//   l_req/we/vec/addr/wdata_*  loader request set, l_lock = keep ownership
//   l_gnt, l_rvalid, l_rdata_* loader grant and read response
//   mem_we/src_sel/addr/wdata_* access issued to dmem
//   mem_q_a, mem_q_b           dmem read data (one-cycle latency)
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int MAX_BURST    = 16,
   parameter int AW           = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p_req,
   input  logic          p_we,
   input  logic          p_vec,
   input  logic [AW-1:0] p_addr,
   input  logic [15:0]   p_wdata_a,
   input  logic [255:0]  p_wdata_b,
   output logic          p_gnt,
   output logic          p_rvalid,
   output logic [15:0]   p_rdata_a,
   output logic [255:0]  p_rdata_b,
   input  logic          l_req,
   input  logic          l_we,
   input  logic          l_vec,
   input  logic [AW-1:0] l_addr,
   input  logic [15:0]   l_wdata_a,
   input  logic [255:0]  l_wdata_b,
   input  logic          l_lock,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [15:0]   l_rdata_a,
   output logic [255:0]  l_rdata_b,
   output logic          mem_we,
   output logic          mem_src_sel,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata_a,
   output logic [255:0]  mem_wdata_b,
   input  logic [15:0]   mem_q_a,
   input  logic [255:0]  mem_q_b
);

   localparam int              BW         = $clog2(MAX_BURST + 1);
   localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [BW-1:0]   BURST_MAX  = BW'(MAX_BURST);

   typedef enum logic [1:0] {P_PRIO, L_FORCE, L_BURST} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    starve_reg, starve_next;
   logic [BW-1:0] burst_reg, burst_next;
   logic          rd_valid_reg, rd_owner_reg;   // owner: 0 = processor, 1 = loader
   logic          win_p, win_l;
   logic          use_prio;
   logic          burst_at_max;

   assign burst_at_max = (burst_reg == BURST_MAX);

   // State register, counters and the read-return tag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= P_PRIO;
         starve_reg   <= '0;
         burst_reg    <= '0;
         rd_valid_reg <= 1'b0;
         rd_owner_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         starve_reg   <= starve_next;
         burst_reg    <= burst_next;
         rd_valid_reg <= (win_p & ~p_we) | (win_l & ~l_we);
         rd_owner_reg <= win_l;
      end
   end

   // Next-state and winner selection. L_FORCE / L_BURST fall through to the
   // processor-priority rules in the same cycle when they do not grant the
   // loader, so an exit never wastes a memory cycle.
   always_comb begin
      state_next  = state_reg;
      starve_next = starve_reg;
      burst_next  = burst_reg;
      win_p       = 1'b0;
      win_l       = 1'b0;
      use_prio    = 1'b0;

      case (state_reg)
         L_FORCE: begin
            if (l_req) begin
               win_l       = 1'b1;
               starve_next = '0;
               if (l_lock) begin
                  state_next = L_BURST;
                  burst_next = BW'(1);
               end else begin
                  state_next = P_PRIO;
               end
            end else begin
               use_prio = 1'b1;
            end
         end
         L_BURST: begin
            if (l_req && l_lock && !(burst_at_max && p_req)) begin
               win_l       = 1'b1;
               starve_next = '0;
               if (!burst_at_max) burst_next = burst_reg + 1'b1;
            end else begin
               use_prio = 1'b1;
            end
         end
         default: use_prio = 1'b1;
      endcase

      if (use_prio) begin
         state_next = P_PRIO;
         burst_next = '0;
         if (p_req) begin
            win_p = 1'b1;
            if (l_req)
               starve_next = (starve_reg == 4'hF) ? 4'hF : starve_reg + 4'd1;
            else
               starve_next = '0;
            if (starve_next >= STARVE_MAX) state_next = L_FORCE;
         end else if (l_req) begin
            win_l       = 1'b1;
            starve_next = '0;
            if (l_lock) begin
               state_next = L_BURST;
               burst_next = BW'(1);
            end
         end else begin
            starve_next = '0;
         end
      end
   end

   // Outputs: grants, mem mux and read return, all held quiet while reset
   // is asserted (reset is applied combinationally, not just at the edge).
   always_comb begin
      p_gnt       = win_p & ~reset;
      l_gnt       = win_l & ~reset;
      mem_we      = 1'b0;
      mem_src_sel = 1'b0;
      mem_addr    = '0;
      mem_wdata_a = '0;
      mem_wdata_b = '0;
      if (p_gnt) begin
         mem_we      = p_we;
         mem_src_sel = p_vec;
         mem_addr    = p_addr;
         mem_wdata_a = p_wdata_a;
         mem_wdata_b = p_wdata_b;
      end else if (l_gnt) begin
         mem_we      = l_we;
         mem_src_sel = l_vec;
         mem_addr    = l_addr;
         mem_wdata_a = l_wdata_a;
         mem_wdata_b = l_wdata_b;
      end

      p_rvalid  = rd_valid_reg & ~rd_owner_reg & ~reset;
      l_rvalid  = rd_valid_reg &  rd_owner_reg & ~reset;
      p_rdata_a = p_rvalid ? mem_q_a : '0;
      p_rdata_b = p_rvalid ? mem_q_b : '0;
      l_rdata_a = l_rvalid ? mem_q_a : '0;
      l_rdata_b = l_rvalid ? mem_q_b : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int STARVE_LIMIT = 8;
   localparam int MAX_BURST    = 16;
   localparam int AW           = 32;

   logic          clk, reset;
   logic          p_req, p_we, p_vec;
   logic [AW-1:0] p_addr;
   logic [15:0]   p_wdata_a;
   logic [255:0]  p_wdata_b;
   logic          p_gnt, p_rvalid;
   logic [15:0]   p_rdata_a;
   logic [255:0]  p_rdata_b;
   logic          l_req, l_we, l_vec, l_lock;
   logic [AW-1:0] l_addr;
   logic [15:0]   l_wdata_a;
   logic [255:0]  l_wdata_b;
   logic          l_gnt, l_rvalid;
   logic [15:0]   l_rdata_a;
   logic [255:0]  l_rdata_b;
   logic          mem_we, mem_src_sel;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata_a;
   logic [255:0]  mem_wdata_b;
   logic [15:0]   mem_q_a;
   logic [255:0]  mem_q_b;

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .p_req(p_req), .p_we(p_we), .p_vec(p_vec), .p_addr(p_addr),
      .p_wdata_a(p_wdata_a), .p_wdata_b(p_wdata_b),
      .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata_a(p_rdata_a), .p_rdata_b(p_rdata_b),
      .l_req(l_req), .l_we(l_we), .l_vec(l_vec), .l_addr(l_addr),
      .l_wdata_a(l_wdata_a), .l_wdata_b(l_wdata_b), .l_lock(l_lock),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata_a(l_rdata_a), .l_rdata_b(l_rdata_b),
      .mem_we(mem_we), .mem_src_sel(mem_src_sel), .mem_addr(mem_addr),
      .mem_wdata_a(mem_wdata_a), .mem_wdata_b(mem_wdata_b),
      .mem_q_a(mem_q_a), .mem_q_b(mem_q_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: how long the loader has been kept waiting, whether it
   // is owed a forced turn, whether it currently holds a locked burst and how
   // many beats it has had, plus the read that is due back next cycle.
   int m_wait;
   bit m_force;
   bit m_burst;
   int m_beats;
   bit m_rd_due;
   bit m_rd_l;

   task automatic model_reset();
      m_wait = 0; m_force = 0; m_burst = 0; m_beats = 0; m_rd_due = 0; m_rd_l = 0;
   endtask

   function automatic bit burst_continues();
      return m_burst && l_req && l_lock && !(m_beats >= MAX_BURST && p_req);
   endfunction

   // 0 = nobody, 1 = processor, 2 = loader
   function automatic int model_grant();
      if (m_force && l_req) return 2;
      if (burst_continues()) return 2;
      if (p_req) return 1;
      if (l_req) return 2;
      return 0;
   endfunction

   task automatic model_update();
      int g;
      bit cont;
      g    = model_grant();
      cont = burst_continues() && !m_force;
      m_rd_due = (g == 1 && !p_we) || (g == 2 && !l_we);
      m_rd_l   = (g == 2);
      if (g == 2) begin
         m_wait  = 0;
         m_force = 0;
         if (cont) begin
            m_beats = (m_beats + 1 > MAX_BURST) ? MAX_BURST : m_beats + 1;
         end else begin
            m_burst = l_lock;
            m_beats = l_lock ? 1 : 0;
         end
      end else if (g == 1) begin
         m_burst = 0;
         m_beats = 0;
         m_wait  = l_req ? ((m_wait + 1 > 15) ? 15 : m_wait + 1) : 0;
         m_force = (m_wait >= STARVE_LIMIT);
      end else begin
         m_wait = 0; m_force = 0; m_burst = 0; m_beats = 0;
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic set_idle();
      p_req = 0; p_we = 0; p_vec = 0; p_addr = '0; p_wdata_a = '0; p_wdata_b = '0;
      l_req = 0; l_we = 0; l_vec = 0; l_addr = '0; l_wdata_a = '0; l_wdata_b = '0; l_lock = 0;
   endtask

   // Advance one clock; the new cycle's inputs are driven 1 time unit after the edge.
   task automatic cycle_end();
      model_update();
      @(posedge clk);
      #1;
      mem_q_a = 16'($urandom);
      mem_q_b = rand256();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_idle();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      mem_q_a = 16'($urandom);
      mem_q_b = rand256();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      p_req = 1; p_we = 1; l_req = 1; l_we = 1;
      #1;
      checks++;
      if ({p_gnt, l_gnt, mem_we} !== 3'b000) begin
         errors++;
         $display("FAIL reset_gates: gnt_p/gnt_l/we = %b, required 000", {p_gnt, l_gnt, mem_we});
      end
      do_reset();
      @(negedge clk);
      checks++;
      if ({p_gnt, l_gnt, p_rvalid, l_rvalid, mem_we, mem_addr} !== '0) begin
         errors++;
         $display("FAIL reset_idle: outputs %b %b %b %b %b %h, required all 0",
                  p_gnt, l_gnt, p_rvalid, l_rvalid, mem_we, mem_addr);
      end
      $display("test_reset done");
      cycle_end();
   endtask

   task automatic test_proc_reads();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         p_req = (i < 3); p_we = 0; p_vec = 0; p_addr = 32'h10;
         @(negedge clk);
         checks++;
         if (p_gnt !== (i < 3)) begin
            errors++;
            $display("FAIL proc_read_gnt[%0d]: got %b, required %b", i, p_gnt, (i < 3));
         end
         checks++;
         if (p_gnt && mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL proc_read_addr[%0d]: got %h, required 00000010", i, mem_addr);
         end
         checks++;
         if ({p_rvalid, l_rvalid} !== {(i >= 1 && i <= 3), 1'b0}) begin
            errors++;
            $display("FAIL proc_read_rvalid[%0d]: p/l got %b%b, required %b0", i, p_rvalid, l_rvalid, (i >= 1 && i <= 3));
         end
         checks++;
         if (p_rvalid && p_rdata_a !== mem_q_a) begin
            errors++;
            $display("FAIL proc_read_data[%0d]: got %h, required %h", i, p_rdata_a, mem_q_a);
         end
         $display("proc_read cycle %0d: p_gnt=%b p_rvalid=%b p_rdata_a=%h", i, p_gnt, p_rvalid, p_rdata_a);
         cycle_end();
      end
   endtask

   task automatic test_starvation();
      do_reset();
      p_req = 1; p_addr = 32'h20; l_req = 1; l_addr = 32'h300; l_lock = 0;
      for (int c = 1; c <= 10; c++) begin
         if (c == 10) l_req = 0;   // loader was served in cycle 9
         @(negedge clk);
         checks++;
         if ({p_gnt, l_gnt} !== ((c == 9) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL starve_gnt[%0d]: p/l got %b%b, required %b", c, p_gnt, l_gnt, ((c == 9) ? 2'b01 : 2'b10));
         end
         if (c == 10) begin
            checks++;
            if (l_rvalid !== 1'b1 || l_rdata_a !== mem_q_a) begin
               errors++;
               $display("FAIL starve_lret: l_rvalid=%b data=%h, required 1 %h", l_rvalid, l_rdata_a, mem_q_a);
            end
         end
         $display("starvation cycle %0d: p_gnt=%b l_gnt=%b", c, p_gnt, l_gnt);
         cycle_end();
      end
      set_idle();
   endtask

   task automatic test_burst();
      do_reset();
      l_req = 1; l_lock = 1; l_we = 1; l_addr = 32'h1000;
      for (int beat = 1; beat <= 17; beat++) begin
         p_req = (beat >= 3); p_addr = 32'h44;
         @(negedge clk);
         checks++;
         if ({p_gnt, l_gnt} !== ((beat <= MAX_BURST) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL burst_gnt[%0d]: p/l got %b%b, required %b", beat, p_gnt, l_gnt, ((beat <= MAX_BURST) ? 2'b01 : 2'b10));
         end
         $display("burst beat %0d: p_gnt=%b l_gnt=%b", beat, p_gnt, l_gnt);
         l_addr = l_addr + 32'd32;
         cycle_end();
      end
      set_idle();
   endtask

   task automatic test_vec_write();
      logic [255:0] pat;
      do_reset();
      pat = {16{16'hA5A5}};
      l_req = 1; l_we = 1; l_vec = 1; l_addr = 32'h200; l_wdata_b = pat; l_wdata_a = 16'h1234;
      @(negedge clk);
      checks++;
      if ({l_gnt, mem_we, mem_src_sel} !== 3'b111 || mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL vec_write_ctl: gnt/we/sel=%b%b%b addr=%h, required 111 00000200", l_gnt, mem_we, mem_src_sel, mem_addr);
      end
      checks++;
      if (mem_wdata_b !== pat) begin
         errors++;
         $display("FAIL vec_write_data: got %h, required %h", mem_wdata_b, pat);
      end
      $display("vec_write: mem_we=%b mem_src_sel=%b mem_addr=%h", mem_we, mem_src_sel, mem_addr);
      cycle_end();
      set_idle();
      @(negedge clk);
      checks++;
      if ({l_rvalid, p_rvalid, mem_we, mem_src_sel} !== 4'b0000 || mem_addr !== '0) begin
         errors++;
         $display("FAIL vec_write_after: rv_l/rv_p/we/sel=%b%b%b%b addr=%h, required 0000 0", l_rvalid, p_rvalid, mem_we, mem_src_sel, mem_addr);
      end
      cycle_end();
   endtask

   task automatic test_alternating();
      do_reset();
      p_req = 1; p_vec = 1; p_addr = 32'h40;
      @(negedge clk);
      checks++;
      if (p_gnt !== 1'b1) begin
         errors++;
         $display("FAIL alt_p_gnt: got %b, required 1", p_gnt);
      end
      cycle_end();
      p_req = 0; l_req = 1; l_vec = 1; l_addr = 32'h80;
      @(negedge clk);
      checks++;
      if ({l_gnt, p_rvalid, l_rvalid} !== 3'b110 || p_rdata_b !== mem_q_b || l_rdata_b !== '0) begin
         errors++;
         $display("FAIL alt_p_ret: gnt_l/rv_p/rv_l=%b%b%b p_data=%h", l_gnt, p_rvalid, l_rvalid, p_rdata_b);
      end
      $display("alternating t+1: p_rvalid=%b l_gnt=%b", p_rvalid, l_gnt);
      cycle_end();
      set_idle();
      @(negedge clk);
      checks++;
      if ({p_rvalid, l_rvalid} !== 2'b01 || l_rdata_b !== mem_q_b || p_rdata_b !== '0) begin
         errors++;
         $display("FAIL alt_l_ret: rv_p/rv_l=%b%b l_data=%h required %h", p_rvalid, l_rvalid, l_rdata_b, mem_q_b);
      end
      $display("alternating t+2: l_rvalid=%b", l_rvalid);
      cycle_end();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      l_req = 1; l_lock = 1; l_we = 0; l_addr = 32'h500;
      for (int beat = 1; beat <= 5; beat++) begin
         @(negedge clk);
         checks++;
         if (l_gnt !== 1'b1 || l_rvalid !== (beat > 1)) begin
            errors++;
            $display("FAIL rst_burst_beat[%0d]: l_gnt=%b l_rvalid=%b", beat, l_gnt, l_rvalid);
         end
         if (beat < 5) cycle_end();
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({p_gnt, l_gnt, p_rvalid, l_rvalid, mem_we} !== 5'b00000) begin
         errors++;
         $display("FAIL rst_burst_async: gnt/rvalid/we = %b, required 00000", {p_gnt, l_gnt, p_rvalid, l_rvalid, mem_we});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      p_req = 1; p_we = 0; p_addr = 32'h60;
      @(negedge clk);
      checks++;
      if ({p_gnt, l_gnt, l_rvalid, p_rvalid} !== 4'b1000) begin
         errors++;
         $display("FAIL rst_burst_after: gnt_p/gnt_l/rv_l/rv_p=%b%b%b%b, required 1000", p_gnt, l_gnt, l_rvalid, p_rvalid);
      end
      $display("reset_mid_burst: after release p_gnt=%b l_gnt=%b", p_gnt, l_gnt);
      cycle_end();
      set_idle();
   endtask

   task automatic test_random();
      int g;
      bit p_hold, l_hold, epv, elv;
      logic [305:0] exp_bus, got_bus;
      logic [545:0] exp_rsp, got_rsp;
      do_reset();
      p_hold = 0; l_hold = 0;
      for (int c = 0; c < 600; c++) begin
         if (!p_hold) begin
            p_req = ($urandom_range(0, 99) < 85);
            p_we = 1'($urandom_range(0, 1)); p_vec = 1'($urandom_range(0, 1));
            p_addr = 32'($urandom); p_wdata_a = 16'($urandom); p_wdata_b = rand256();
         end
         if (!l_hold) begin
            l_req = ($urandom_range(0, 99) < 60);
            l_we = 1'($urandom_range(0, 1)); l_vec = 1'($urandom_range(0, 1));
            l_lock = ($urandom_range(0, 3) != 0);
            l_addr = 32'($urandom); l_wdata_a = 16'($urandom); l_wdata_b = rand256();
         end
         @(negedge clk);
         g = model_grant();
         checks++;
         if ({p_gnt, l_gnt} !== {g == 1, g == 2}) begin
            errors++;
            $display("FAIL rnd_gnt[%0d]: p/l got %b%b, required %b%b", c, p_gnt, l_gnt, g == 1, g == 2);
         end
         if (g == 1)      exp_bus = {p_we, p_vec, p_addr, p_wdata_a, p_wdata_b};
         else if (g == 2) exp_bus = {l_we, l_vec, l_addr, l_wdata_a, l_wdata_b};
         else             exp_bus = '0;
         got_bus = {mem_we, mem_src_sel, mem_addr, mem_wdata_a, mem_wdata_b};
         checks++;
         if (got_bus !== exp_bus) begin
            errors++;
            $display("FAIL rnd_mem[%0d]: got %h, required %h", c, got_bus, exp_bus);
         end
         epv = m_rd_due && !m_rd_l;
         elv = m_rd_due && m_rd_l;
         exp_rsp = {epv, epv ? mem_q_a : 16'h0, epv ? mem_q_b : 256'h0,
                    elv, elv ? mem_q_a : 16'h0, elv ? mem_q_b : 256'h0};
         got_rsp = {p_rvalid, p_rdata_a, p_rdata_b, l_rvalid, l_rdata_a, l_rdata_b};
         checks++;
         if (got_rsp !== exp_rsp) begin
            errors++;
            $display("FAIL rnd_rsp[%0d]: rvalid p/l got %b%b, required %b%b", c, p_rvalid, l_rvalid, epv, elv);
         end
         $display("random cycle %0d: p_req=%b l_req=%b l_lock=%b p_gnt=%b l_gnt=%b p_rvalid=%b l_rvalid=%b",
                  c, p_req, l_req, l_lock, p_gnt, l_gnt, p_rvalid, l_rvalid);
         p_hold = p_req && (g != 1);
         l_hold = l_req && (g != 2);
         cycle_end();
      end
      set_idle();
   endtask

   initial begin
      reset = 1'b1;
      set_idle();
      mem_q_a = '0;
      mem_q_b = '0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_proc_reads();
      test_starvation();
      test_burst();
      test_vec_write();
      test_alternating();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
